// File: rtl/nand_op_scheduler_if.sv
// Request/grant/result bundle between two requesters and the NAND-only
// logic scheduler.
interface nand_op_scheduler_if #(
    parameter int W = 8
);
    logic [1:0]   req;
    logic [1:0]   op0;
    logic [1:0]   op1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [1:0]   gnt;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] result;

    modport master (
        output req, op0, op1, a0, b0, a1, b1,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, op0, op1, a0, b0, a1, b1,
        output gnt, busy, done, done_id, result
    );
endinterface

// File: rtl/nand_op_scheduler.sv
// Two-requester round-robin scheduler that evaluates NOT/AND/OR/XOR using a
// single shared W-bit NAND gate, one NAND evaluation per CALC cycle.
module nand_op_scheduler #(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    nand_op_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_NOT, OP_AND, OP_OR, OP_XOR} op_t;
    typedef enum logic [1:0] {D_T, D_X, D_Y, D_R} dest_t;

    state_t       r_state;
    state_t       w_state_nxt;
    op_t          r_op;
    logic [1:0]   r_step;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_t;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_result;
    logic [1:0]   r_gnt;
    logic         r_done;
    logic         r_done_id;
    logic         r_last_id;

    logic         w_accept;
    logic         w_winner;
    logic         w_last;
    logic [W-1:0] w_src_x;
    logic [W-1:0] w_src_y;
    logic [W-1:0] w_nand;
    dest_t        w_dest;

    // Contested requests go to whoever did not win last time.
    always_comb begin
        w_winner = 1'b0;
        case (bus.req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_id;
            default: w_winner = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // An op with code k needs k+1 NAND steps, so the last step index equals the code.
    assign w_last = (r_step == r_op);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = CALC;
                    w_accept    = 1'b1;
                end
            end
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_src_x = r_a;
        w_src_y = r_a;
        w_dest  = D_R;
        case (r_op)
            OP_NOT: begin
                w_src_x = r_a; w_src_y = r_a; w_dest = D_R;
            end
            OP_AND: begin
                case (r_step)
                    2'd0:    begin w_src_x = r_a; w_src_y = r_b; w_dest = D_T; end
                    default: begin w_src_x = r_t; w_src_y = r_t; w_dest = D_R; end
                endcase
            end
            OP_OR: begin
                case (r_step)
                    2'd0:    begin w_src_x = r_a; w_src_y = r_a; w_dest = D_X; end
                    2'd1:    begin w_src_x = r_b; w_src_y = r_b; w_dest = D_Y; end
                    default: begin w_src_x = r_x; w_src_y = r_y; w_dest = D_R; end
                endcase
            end
            OP_XOR: begin
                case (r_step)
                    2'd0:    begin w_src_x = r_a; w_src_y = r_b; w_dest = D_T; end
                    2'd1:    begin w_src_x = r_a; w_src_y = r_t; w_dest = D_X; end
                    2'd2:    begin w_src_x = r_b; w_src_y = r_t; w_dest = D_Y; end
                    default: begin w_src_x = r_x; w_src_y = r_y; w_dest = D_R; end
                endcase
            end
            default: begin
                w_src_x = r_a; w_src_y = r_a; w_dest = D_R;
            end
        endcase
    end

    // The one and only NAND unit in the datapath.
    assign w_nand = ~(w_src_x & w_src_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_NOT;
            r_step    <= 2'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_t       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_result  <= '0;
            r_gnt     <= 2'b00;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_last_id <= 1'b1;
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 1'b0;
            if (w_accept) begin
                r_op      <= w_winner ? op_t'(bus.op1) : op_t'(bus.op0);
                r_a       <= w_winner ? bus.a1 : bus.a0;
                r_b       <= w_winner ? bus.b1 : bus.b0;
                r_step    <= 2'd0;
                r_last_id <= w_winner;
                r_gnt     <= w_winner ? 2'b10 : 2'b01;
            end else if (r_state == CALC) begin
                r_step <= r_step + 2'd1;
                case (w_dest)
                    D_T:     r_t <= w_nand;
                    D_X:     r_x <= w_nand;
                    D_Y:     r_y <= w_nand;
                    default: r_result <= w_nand;
                endcase
                if (w_last) begin
                    r_done    <= 1'b1;
                    r_done_id <= r_last_id;
                end
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.result  = r_result;
endmodule

// File: tb/tb_nand_op_scheduler.sv
// Directed bench for nand_op_scheduler: per-op results and latency, round-robin
// arbitration, operand latching and mid-operation reset.
module tb_nand_op_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    nand_op_scheduler_if #(.W(8)) bus ();

    nand_op_scheduler #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},     32'(bus.gnt),     32'h0);
        check({tag, "_busy"},    32'(bus.busy),    32'h0);
        check({tag, "_done"},    32'(bus.done),    32'h0);
        check({tag, "_done_id"}, 32'(bus.done_id), 32'h0);
        check({tag, "_result"},  32'(bus.result),  32'h0);
    endtask

    // Issue one request from an idle scheduler and follow it cycle by cycle.
    task automatic run_op(input string tag, input logic id, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_r, input int n, input bit mutate);
        if (id) begin bus.op1 = op; bus.a1 = a; bus.b1 = b; end
        else    begin bus.op0 = op; bus.a0 = a; bus.b0 = b; end
        bus.req = id ? 2'b10 : 2'b01;
        @(negedge clk);
        check({tag, "_gnt"},  32'(bus.gnt),  id ? 32'h2 : 32'h1);
        check({tag, "_busy"}, 32'(bus.busy), 32'h1);
        bus.req = 2'b00;
        if (mutate) begin
            if (id) bus.a1 = 8'hFF; else bus.a0 = 8'hFF;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check({tag, "_gnt_lo"}, 32'(bus.gnt), 32'h0);
            if (k < n) check({tag, "_early_done"}, 32'(bus.done), 32'h0);
        end
        check({tag, "_done"},    32'(bus.done),    32'h1);
        check({tag, "_result"},  32'(bus.result),  32'(exp_r));
        check({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(bus.busy),   32'h0);
        check({tag, "_done_lo"},   32'(bus.done),   32'h0);
        check({tag, "_held"},      32'(bus.result), 32'(exp_r));
    endtask

    initial begin
        int grants;
        int cyc;
        logic exp_id;

        checks = 0;
        errors = 0;
        bus.req = 2'b00;
        bus.op0 = 2'b00; bus.op1 = 2'b00;
        bus.a0 = 8'h00;  bus.b0 = 8'h00;
        bus.a1 = 8'h00;  bus.b1 = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("not0",  1'b0, 2'b00, 8'h0F, 8'h00, 8'hF0, 1, 1'b0);
        run_op("and1",  1'b1, 2'b01, 8'hCC, 8'hAA, 8'h88, 2, 1'b0);
        run_op("or1",   1'b1, 2'b10, 8'hCC, 8'hAA, 8'hEE, 3, 1'b0);
        run_op("xor1",  1'b1, 2'b11, 8'hCC, 8'hAA, 8'h66, 4, 1'b0);
        run_op("not1",  1'b1, 2'b00, 8'hCC, 8'h55, 8'h33, 1, 1'b0);
        run_op("hold0", 1'b0, 2'b00, 8'h0F, 8'h00, 8'hF0, 1, 1'b1);

        // Simultaneous requests right after reset: requester 0 first.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.op0 = 2'b11; bus.a0 = 8'hCC; bus.b0 = 8'hAA;
        bus.op1 = 2'b11; bus.a1 = 8'hF0; bus.b1 = 8'h0F;
        bus.req = 2'b11;
        @(negedge clk);
        check("sim_gnt0", 32'(bus.gnt), 32'h1);
        bus.req = 2'b10;
        repeat (4) @(negedge clk);
        check("sim_done0",   32'(bus.done),    32'h1);
        check("sim_id0",     32'(bus.done_id), 32'h0);
        check("sim_res0",    32'(bus.result),  32'h66);
        @(negedge clk);
        check("sim_gap_gnt", 32'(bus.gnt),     32'h0);
        @(negedge clk);
        check("sim_gnt1",    32'(bus.gnt),     32'h2);
        bus.req = 2'b00;
        repeat (4) @(negedge clk);
        check("sim_done1",   32'(bus.done),    32'h1);
        check("sim_id1",     32'(bus.done_id), 32'h1);
        check("sim_res1",    32'(bus.result),  32'hFF);
        @(negedge clk);

        // Fairness: both requesters held high across four NOT operations.
        bus.op0 = 2'b00; bus.a0 = 8'h01;
        bus.op1 = 2'b00; bus.a1 = 8'h02;
        bus.req = 2'b11;
        grants = 0;
        cyc = 0;
        exp_id = 1'b0;
        while (grants < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            check("fair_not_two_hot", 32'(bus.gnt == 2'b11), 32'h0);
            if (bus.gnt != 2'b00) begin
                check("fair_order", 32'(bus.gnt), exp_id ? 32'h2 : 32'h1);
                exp_id = ~exp_id;
                grants++;
                if (grants == 4) bus.req = 2'b00;
            end
            if (bus.done) check("fair_result", 32'(bus.result),
                                bus.done_id ? 32'hFD : 32'hFE);
        end
        check("fair_grants", 32'(grants), 32'd4);
        repeat (4) @(negedge clk);
        check("fair_idle", 32'(bus.busy), 32'h0);

        // Reset during step 2 of an XOR.
        bus.op0 = 2'b11; bus.a0 = 8'hCC; bus.b0 = 8'hAA;
        bus.req = 2'b01;
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(bus.done), 32'h0);
        check("midrst_busy",    32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(bus.busy), 32'h0);
        run_op("post_xor", 1'b0, 2'b11, 8'hCC, 8'hAA, 8'h66, 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
